// File: rtl/mem_loader_if.sv
// mem_loader_if: start/halt control, word stream and memory-write bus for mem_loader.
// master = stimulus side (drives start/halt/counts/stream), slave = loader side.
interface mem_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic              halt;
    logic [ADDR_W:0]   imem_count;
    logic [ADDR_W:0]   dmem_count;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] instructionAddress;
    logic              imem_we;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dataAddress;
    logic              writeEnable;
    logic              cpu_run;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    modport master (
        output start, halt, imem_count, dmem_count, in_valid, in_data,
        input  in_ready, instruction, instructionAddress, imem_we,
               data, dataAddress, writeEnable, cpu_run, busy, done, checksum
    );

    modport slave (
        input  start, halt, imem_count, dmem_count, in_valid, in_data,
        output in_ready, instruction, instructionAddress, imem_we,
               data, dataAddress, writeEnable, cpu_run, busy, done, checksum
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: streams imem_count instruction words then dmem_count data words
// into the two memories, then releases the CPU (RUN) until halt.
// Optional: define LOADER_CHECKSUM_EN to XOR every accepted word into checksum.
module mem_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7
) (
    input logic         clk,
    input logic         reset,
    mem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD_I, LOAD_D, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic [ADDR_W:0]   i_idx_q, i_idx_d, d_idx_q, d_idx_d;
    logic [DATA_W-1:0] instr_q, instr_d, data_q, data_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d, daddr_q, daddr_d;
    logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
    logic              done_q, done_d;
    logic              loading;

    assign loading = (state_q == LOAD_I) || (state_q == LOAD_D);

    // Next-state, counters and registered write-port values
    always_comb begin
        state_d   = state_q;
        i_cnt_d   = i_cnt_q;
        d_cnt_d   = d_cnt_q;
        i_idx_d   = i_idx_q;
        d_idx_d   = d_idx_q;
        instr_d   = instr_q;
        data_d    = data_q;
        iaddr_d   = iaddr_q;
        daddr_d   = daddr_q;
        imem_we_d = 1'b0;
        dmem_we_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_cnt_d = bus.imem_count;
                    d_cnt_d = bus.dmem_count;
                    i_idx_d = '0;
                    d_idx_d = '0;
                    if (bus.imem_count != '0)      state_d = LOAD_I;
                    else if (bus.dmem_count != '0) state_d = LOAD_D;
                    else                           state_d = RUN;
                end
            end
            LOAD_I: begin
                if (bus.in_valid) begin
                    instr_d   = bus.in_data;
                    iaddr_d   = i_idx_q[ADDR_W-1:0];
                    imem_we_d = 1'b1;
                    i_idx_d   = i_idx_q + 1'b1;
                    if (i_idx_d == i_cnt_q) state_d = (d_cnt_q == '0) ? RUN : LOAD_D;
                end
            end
            LOAD_D: begin
                if (bus.in_valid) begin
                    data_d    = bus.in_data;
                    daddr_d   = d_idx_q[ADDR_W-1:0];
                    dmem_we_d = 1'b1;
                    d_idx_d   = d_idx_q + 1'b1;
                    if (d_idx_d == d_cnt_q) state_d = RUN;
                end
            end
            RUN: begin
                if (bus.halt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == RUN) && (state_q != RUN);
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            i_cnt_q   <= '0;
            d_cnt_q   <= '0;
            i_idx_q   <= '0;
            d_idx_q   <= '0;
            instr_q   <= '0;
            data_q    <= '0;
            iaddr_q   <= '0;
            daddr_q   <= '0;
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_cnt_q   <= i_cnt_d;
            d_cnt_q   <= d_cnt_d;
            i_idx_q   <= i_idx_d;
            d_idx_q   <= d_idx_d;
            instr_q   <= instr_d;
            data_q    <= data_d;
            iaddr_q   <= iaddr_d;
            daddr_q   <= daddr_d;
            imem_we_q <= imem_we_d;
            dmem_we_q <= dmem_we_d;
            done_q    <= done_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // Running XOR of accepted words, cleared when a load starts
    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && bus.start) csum_d = '0;
        else if (loading && bus.in_valid) csum_d = csum_q ^ bus.in_data;
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign bus.checksum = csum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.in_ready           = loading;
    assign bus.busy               = loading;
    assign bus.cpu_run            = (state_q == RUN);
    assign bus.done               = done_q;
    assign bus.instruction        = instr_q;
    assign bus.instructionAddress = iaddr_q;
    assign bus.imem_we            = imem_we_q;
    assign bus.data               = data_q;
    assign bus.dataAddress        = daddr_q;
    assign bus.writeEnable        = dmem_we_q;
endmodule
